fp5_divider: RTL and testbench

//  Iterative FP5 divider (1 sign, 3-bit exponent with bias 3, 1 stored mantissa bit, implicit leading 1).

---
 rtl/fp5_divider.sv | 184 ++++++++++++++++++
 tb/tb_fp5_divider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fp5_divider.sv
// fp5_divider
//   Iterative FP5 divider: {sign, exp[2:0] bias 3, 1 stored mantissa bit}.
//   Restoring radix-2 division produces one quotient bit per clock, then one
//   normalise/round cycle, then the result is held until it is accepted.
//   Build option: define FPDIV_ROUND_EN for round-to-nearest-even; otherwise
//   the quotient is truncated. Both builds have identical timing.
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake (in_ready high only when idle)
//   a, b                dividend and divisor
//   out_valid, out_ready result handshake
//   fquot               quotient
//   dz_flag             divide by zero
//   ovf_flag            result saturated
//   unf_flag            result flushed to zero
module fp5_divider #(
    parameter int w    = 5,
    parameter int BIAS = 3,
    parameter int ITER = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [w-1:0] fquot,
    output logic         dz_flag,
    output logic         ovf_flag,
    output logic         unf_flag
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
    state_t state, state_nx;

    logic            sgn;
    logic [2:0]      ea, eb;
    logic            mbit;
    logic [2:0]      rem;
    logic [ITER-1:0] quo;
    logic [CW-1:0]   cnt;

    // one restoring-division step
    logic [2:0] mb3, sub, rem_nx;
    logic       ge;

    always_comb begin
        mb3    = {1'b0, 1'b1, mbit};
        ge     = (rem >= mb3);
        sub    = ge ? (rem - mb3) : rem;
        rem_nx = {sub[1:0], 1'b0};
    end

    // normalise, round and special-case selection
    logic signed [4:0] e, ex;
    logic              man;
    logic [w-1:0]      res;
    logic              res_dz, res_ovf, res_unf;
`ifdef FPDIV_ROUND_EN
    logic              guard, sticky;
`else
    logic              unused_bits;
    assign unused_bits = ^{quo[0], rem};
`endif

    always_comb begin
        e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 5'(BIAS);
        if (quo[3]) begin
            man = quo[2];
            ex  = e;
        end else begin
            man = quo[1];
            ex  = e - 5'sd1;
        end
`ifdef FPDIV_ROUND_EN
        if (quo[3]) begin
            guard  = quo[1];
            sticky = (rem != 3'd0) | quo[0];
        end else begin
            guard  = quo[0];
            sticky = (rem != 3'd0);
        end
        if (guard && (sticky || man)) begin
            // mantissa carry-out renormalises into the exponent
            if (man) begin
                man = 1'b0;
                ex  = ex + 5'sd1;
            end else begin
                man = 1'b1;
            end
        end
`endif
        res     = {sgn, ex[2:0], man};
        res_dz  = 1'b0;
        res_ovf = 1'b0;
        res_unf = 1'b0;
        if (eb == 3'd0) begin
            res    = {sgn, 3'b111, 1'b1};
            res_dz = 1'b1;
        end else if (ea == 3'd0) begin
            res = {sgn, 4'b0000};
        end else if (ex > 5'sd7) begin
            res     = {sgn, 3'b111, 1'b1};
            res_ovf = 1'b1;
        end else if (ex < 5'sd1) begin
            res     = {sgn, 4'b0000};
            res_unf = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = DIV;
            end
            DIV:  if (cnt == LAST) state_nx = NORM;
            NORM: state_nx = DONE;
            DONE: if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sgn       <= 1'b0;
            ea        <= '0;
            eb        <= '0;
            mbit      <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            fquot     <= '0;
            dz_flag   <= 1'b0;
            ovf_flag  <= 1'b0;
            unf_flag  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    sgn  <= a[4] ^ b[4];
                    ea   <= a[3:1];
                    eb   <= b[3:1];
                    mbit <= b[0];
                    rem  <= {1'b0, 1'b1, a[0]};
                    quo  <= '0;
                    cnt  <= '0;
                end
                DIV: begin
                    quo <= {quo[ITER-2:0], ge};
                    rem <= rem_nx;
                    cnt <= cnt + 1'b1;
                end
                NORM: begin
                    fquot    <= res;
                    dz_flag  <= res_dz;
                    ovf_flag <= res_ovf;
                    unf_flag <= res_unf;
                end
                DONE: begin
                    // first DONE cycle registers the result onto out_valid,
                    // giving the fixed six-edge accept-to-valid latency
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        dz_flag   <= 1'b0;
                        ovf_flag  <= 1'b0;
                        unf_flag  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp5_divider.sv
// tb_fp5_divider
//   Directed vectors with hand-computed quotients for fp5_divider, covering
//   latency, rounding mode, signs, specials, backpressure and mid-run reset.
module tb_fp5_divider;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] a, b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] fquot;
    logic       dz_flag, ovf_flag, unf_flag;

    int errors = 0;
    int checks = 0;

    fp5_divider dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .fquot(fquot),
        .dz_flag(dz_flag), .ovf_flag(ovf_flag), .unf_flag(unf_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, expv);
        end
    endtask

    // drive one operand pair; returns after the accept edge (+1)
    task automatic launch(input logic [4:0] va, input logic [4:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~va;   // captured operands must not follow these
        b = ~vb;
    endtask

    task automatic wait_valid(input string tag, input int expect_lat);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 8'(n), 8'(expect_lat));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_rel"}, {5'b0, out_valid, in_ready, dz_flag | ovf_flag | unf_flag}, 8'b0000_0010);
    endtask

    task automatic run(input string tag, input logic [4:0] va, input logic [4:0] vb,
                       input logic [4:0] eq, input logic edz, input logic eovf, input logic eunf);
        launch(va, vb);
        wait_valid(tag, 6);
        check({tag, "_q"}, {3'b0, fquot}, {3'b0, eq});
        check({tag, "_flags"}, {5'b0, dz_flag, ovf_flag, unf_flag}, {5'b0, edz, eovf, eunf});
        release_result(tag);
    endtask

    logic [4:0] exp_r3;
    logic [4:0] held_q;
    logic [2:0] held_f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef FPDIV_ROUND_EN
        exp_r3 = 5'b0_010_1;
`else
        exp_r3 = 5'b0_010_0;
`endif
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {3'b0, in_ready, out_valid, dz_flag, ovf_flag, unf_flag}, 8'b0001_0000);
        check("reset_q", {3'b0, fquot}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        run("one_by_one",   5'b0_011_0, 5'b0_011_0, 5'b0_011_0, 0, 0, 0);
        run("three_by_1p5", 5'b0_100_1, 5'b0_011_1, 5'b0_100_0, 0, 0, 0);
        run("one_by_1p5",   5'b0_011_0, 5'b0_011_1, exp_r3,     0, 0, 0);
        run("1p5_by_one",   5'b0_011_1, 5'b0_011_0, 5'b0_011_1, 0, 0, 0);
        run("neg_sign",     5'b1_011_0, 5'b0_011_0, 5'b1_011_0, 0, 0, 0);
        run("div_zero",     5'b0_011_0, 5'b0_000_1, 5'b0_111_1, 1, 0, 0);
        run("div_zero_neg", 5'b1_011_0, 5'b0_000_0, 5'b1_111_1, 1, 0, 0);
        run("zero_by_zero", 5'b0_000_0, 5'b1_000_0, 5'b1_111_1, 1, 0, 0);
        run("a_zero",       5'b0_000_1, 5'b1_011_0, 5'b1_000_0, 0, 0, 0);
        run("overflow",     5'b0_111_0, 5'b0_001_0, 5'b0_111_1, 0, 1, 0);
        run("max_normal",   5'b0_111_1, 5'b0_011_0, 5'b0_111_1, 0, 0, 0);
        run("underflow",    5'b0_001_0, 5'b0_111_0, 5'b0_000_0, 0, 0, 1);
        run("unf_edge",     5'b1_001_0, 5'b0_011_1, 5'b1_000_0, 0, 0, 1);
        run("min_normal",   5'b0_001_0, 5'b0_011_0, 5'b0_001_0, 0, 0, 0);

        // backpressure: result and flags held, new requests ignored
        launch(5'b0_111_0, 5'b0_001_0);
        wait_valid("bp", 6);
        held_q = fquot;
        held_f = {dz_flag, ovf_flag, unf_flag};
        check("bp_q", {3'b0, held_q}, 8'b0000_1111);
        @(negedge clk);
        a = 5'b0_011_0;
        b = 5'b0_011_0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {in_ready, out_valid, held_f == {dz_flag, ovf_flag, unf_flag}, fquot},
                  {3'b011, held_q});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release", {6'b0, in_ready, out_valid}, 8'b0000_0010);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_no_accept", {7'b0, in_ready}, 8'b0000_0001);

        // reset during the second DIV cycle aborts the operation
        launch(5'b0_100_1, 5'b0_011_1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort", {2'b0, in_ready, out_valid, fquot == 5'b0, dz_flag, ovf_flag, unf_flag},
              8'b0010_1000);
        @(negedge clk);
        reset = 1'b0;
        run("after_abort",  5'b0_100_1, 5'b0_011_1, 5'b0_100_0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
